// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with shift-add multiply and restoring divide.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIVU acts as undefined.
module alu_seq_unit #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1100;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1101;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
`ifdef ALU_SEQ_DIV_EN
  logic             r_div;
  logic             r_dbz;
  logic             w_is_div;
  logic             w_b_zero;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_trial;
`endif

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_sc_lo;
  logic             w_sc_ovf;
  logic             w_is_mul;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_it_hi;
  logic [WIDTH-1:0] w_it_lo;

  assign w_shamt  = dataB[SHW-1:0];
  assign w_is_mul = (op == OP_MULTU);
`ifdef ALU_SEQ_DIV_EN
  assign w_is_div = (op == OP_DIVU);
  assign w_b_zero = (dataB == '0);
`endif

  always_comb begin
    w_sum    = dataA + dataB;
    w_dif    = dataA - dataB;
    w_sc_lo  = '0;
    w_sc_ovf = 1'b0;
    case (op)
      OP_AND: w_sc_lo = dataA & dataB;
      OP_OR:  w_sc_lo = dataA | dataB;
      OP_ADD: begin
        w_sc_lo  = w_sum;
        w_sc_ovf = (dataA[WIDTH-1] == dataB[WIDTH-1])
                && (w_sum[WIDTH-1] != dataA[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_lo  = w_dif;
        w_sc_ovf = (dataA[WIDTH-1] != dataB[WIDTH-1])
                && (w_dif[WIDTH-1] != dataA[WIDTH-1]);
      end
      OP_SLT: begin
        w_sc_lo = {{(WIDTH-1){1'b0}},
                   ($signed(dataA) < $signed(dataB))};
      end
      OP_SLL: w_sc_lo = dataA << w_shamt;
      OP_SRL: w_sc_lo = dataA >> w_shamt;
      default: ;
    endcase
  end

  // One multiply or divide step over the {hi, lo} working pair.
  always_comb begin
    w_mul_sum = {1'b0, r_res_hi}
              + (r_res_lo[0] ? {1'b0, r_opnd} : '0);
    w_it_hi   = w_mul_sum[WIDTH:1];
    w_it_lo   = {w_mul_sum[0], r_res_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    w_rsh     = {r_res_hi, r_res_lo[WIDTH-1]};
    w_trial   = w_rsh - {1'b0, r_opnd};
    if (r_div) begin
      if (w_trial[WIDTH]) begin
        w_it_hi = w_rsh[WIDTH-1:0];
        w_it_lo = {r_res_lo[WIDTH-2:0], 1'b0};
      end else begin
        w_it_hi = w_trial[WIDTH-1:0];
        w_it_lo = {r_res_lo[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_opnd      <= '0;
      r_res_lo    <= '0;
      r_res_hi    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      r_div       <= 1'b0;
      r_dbz       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
`ifdef ALU_SEQ_DIV_EN
            r_dbz      <= 1'b0;
            r_div      <= 1'b0;
`endif
            if (w_is_mul) begin
              r_state  <= S_BUSY;
              r_opnd   <= dataA;
              r_res_hi <= '0;
              r_res_lo <= dataB;
`ifdef ALU_SEQ_DIV_EN
            end else if (w_is_div && w_b_zero) begin
              r_state     <= S_DONE;
              r_res_lo    <= '1;
              r_res_hi    <= dataA;
              r_zero      <= 1'b0;
              r_dbz       <= 1'b1;
              r_out_valid <= 1'b1;
            end else if (w_is_div) begin
              r_state  <= S_BUSY;
              r_div    <= 1'b1;
              r_opnd   <= dataB;
              r_res_hi <= '0;
              r_res_lo <= dataA;
`endif
            end else begin
              r_state     <= S_DONE;
              r_res_lo    <= w_sc_lo;
              r_res_hi    <= '0;
              r_zero      <= (w_sc_lo == '0);
              r_ovf       <= w_sc_ovf;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          r_cnt    <= r_cnt + SHW'(1);
          r_res_hi <= w_it_hi;
          r_res_lo <= w_it_lo;
          if (r_cnt == SHW'(WIDTH-1)) begin
            r_state     <= S_DONE;
            r_zero      <= (w_it_lo == '0);
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result_lo   = r_res_lo;
  assign result_hi   = r_res_hi;
  assign zero        = r_zero;
  assign overflow    = r_ovf;
`ifdef ALU_SEQ_DIV_EN
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: scoreboard bench for alu_seq_unit.
// Expected results are queued at accept and compared on out_valid.
module tb_alu_seq_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         overflow;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .dataA(dataA),
    .dataB(dataB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result_lo(result_lo),
    .result_hi(result_hi),
    .zero(zero),
    .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] lo,
                              input logic [W-1:0] hi,
                              input logic ovf,
                              input logic dbz,
                              input int lat);
    exp_t e;
    e.lo  = lo;
    e.hi  = hi;
    e.ovf = ovf;
    e.dbz = dbz;
    e.lat = lat;
    return e;
  endfunction

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t   e;
    longint s;
    logic [63:0] p;
    e = mk('0, '0, 1'b0, 1'b0, 0);
    case (o)
      4'b0000: e.lo = a & b;
      4'b0001: e.lo = a | b;
      4'b0010: begin
        e.lo  = a + b;
        s     = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (s != longint'($signed(e.lo)));
      end
      4'b0110: begin
        e.lo  = a - b;
        s     = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (s != longint'($signed(e.lo)));
      end
      4'b0111: e.lo = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: e.lo = a << b[4:0];
      4'b1001: e.lo = a >> b[4:0];
      4'b1100: begin
        p     = {32'b0, a} * {32'b0, b};
        e.lo  = p[31:0];
        e.hi  = p[63:32];
        e.lat = W;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [3:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input exp_t e);
    @(negedge clk);
    check("acc_rdy", in_ready, 1);
    op       = o;
    dataA    = a;
    dataB    = b;
    in_valid = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   n;
    bit   rdy_seen;
    e        = sbq.pop_front();
    n        = 0;
    rdy_seen = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_lat"}, n, e.lat);
    check({tag, "_busyrdy"}, rdy_seen, 0);
    check({tag, "_lo"}, result_lo, e.lo);
    check({tag, "_hi"}, result_hi, e.hi);
    check({tag, "_zero"}, zero, (e.lo == '0));
    check({tag, "_ovf"}, overflow, e.ovf);
    check({tag, "_dbz"}, div_by_zero, e.dbz);
    check({tag, "_donerdy"}, in_ready, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rel_vld"}, out_valid, 0);
    check({tag, "_rel_rdy"}, in_ready, 1);
  endtask

  initial begin
    logic [3:0] ops[8];
    logic [3:0] o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t e;
    bit   stable;

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1000, 4'b1001, 4'b1100};
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    dataA     = '0;
    dataB     = '0;
    #2;
    check("rst_rdy", in_ready, 1);
    check("rst_vld", out_valid, 0);
    check("rst_lo", result_lo, 0);
    check("rst_hi", result_hi, 0);
    check("rst_flags", {zero, overflow, div_by_zero}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(4'b0010, 20, 15, mk(35, 0, 0, 0, 0));
    collect("add");
    issue(4'b0110, 15, 20, mk(32'hFFFF_FFFB, 0, 0, 0, 0));
    collect("sub");
    issue(4'b0111, 20, 15, mk(0, 0, 0, 0, 0));
    collect("slt0");
    issue(4'b0111, 32'hFFFF_FFFF, 1, mk(1, 0, 0, 0, 0));
    collect("slt1");
    issue(4'b0010, 32'h7FFF_FFFF, 1, mk(32'h8000_0000, 0, 1, 0, 0));
    collect("add_ovf");
    issue(4'b0110, 32'h8000_0000, 1, mk(32'h7FFF_FFFF, 0, 1, 0, 0));
    collect("sub_ovf");
    issue(4'b1000, 32'h1234_5678, 32'h20, mk(32'h1234_5678, 0, 0, 0, 0));
    collect("sll0");
    issue(4'b1001, 32'h8000_0000, 31, mk(1, 0, 0, 0, 0));
    collect("srl31");
    issue(4'b0011, 32'hFFFF_FFFF, 5, mk(0, 0, 0, 0, 0));
    collect("undef");
    issue(4'b1100, 5, 10, mk(50, 0, 0, 0, W));
    collect("mul");
    issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          mk(32'h0000_0001, 32'hFFFF_FFFE, 0, 0, W));
    collect("mul_max");
    issue(4'b1100, 0, 32'hDEAD_BEEF, mk(0, 0, 0, 0, W));
    collect("mul_z");
`ifdef ALU_SEQ_DIV_EN
    issue(4'b1101, 100, 7, mk(14, 2, 0, 0, W));
    collect("div");
    issue(4'b1101, 9, 0, mk(32'hFFFF_FFFF, 9, 0, 1, 0));
    collect("div0");
    issue(4'b1101, 32'hFFFF_FFFF, 32'h0001_0000,
          mk(32'h0000_FFFF, 32'h0000_FFFF, 0, 0, W));
    collect("div_big");
`else
    issue(4'b1101, 100, 7, mk(0, 0, 0, 0, 0));
    collect("div_off");
    issue(4'b1101, 9, 0, mk(0, 0, 0, 0, 0));
    collect("div0_off");
`endif

    issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00,
          mk(32'hF000_F000, 0, 0, 0, 0));
    e      = sbq.pop_front();
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      op       = 4'b0010;
      dataA    = 32'h1;
      dataB    = 32'h1;
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || result_lo !== e.lo
          || result_hi !== e.hi) stable = 0;
    end
    in_valid = 1'b0;
    check("bp_hold", stable, 1);
    check("bp_lo", result_lo, 32'hF000_F000);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_idle_rdy", in_ready, 1);
    check("bp_idle_vld", out_valid, 0);
    @(posedge clk);
    #1;
    check("bp_no_extra", out_valid, 0);

    issue(4'b1100, 7, 9, mk(63, 0, 0, 0, W));
    void'(sbq.pop_front());
    repeat (11) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mrst_vld", out_valid, 0);
    check("mrst_rdy", in_ready, 1);
    check("mrst_lo", result_lo, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mrst_novld", out_valid, 0);
    issue(4'b1000, 1, 31, mk(32'h8000_0000, 0, 0, 0, 0));
    collect("sll31");

    for (int i = 0; i < 16; i++) begin
      o = ops[$urandom_range(0, 7)];
      a = $urandom;
      b = (i % 4 == 0) ? W'($urandom_range(0, 40)) : $urandom;
      issue(o, a, b, model(o, a, b));
      collect("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, handshaked successor to the combinational 32-bit ALU and the standalone clocked multiplier.
- Single-cycle ops: AND, OR, ADD, SUB, SLT, SLL, SRL.
- Multi-cycle ops: unsigned shift-add multiply and restoring divide, both inside one FSM.
- Sits between the datapath operand registers and writeback; accepts one operation at a time and holds its result until writeback takes it.

Parameters:
- WIDTH, 32: operand and result word width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept an operation
- op  in  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLL, 1001 SRL, 1100 MULTU, 1101 DIVU
- dataA  in  WIDTH  operand A
- dataB  in  WIDTH  operand B; shift amount is dataB[SHW-1:0]
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result_lo  out  WIDTH  main result; MULTU low word; DIVU quotient
- result_hi  out  WIDTH  MULTU high word; DIVU remainder; 0 for all other ops
- zero  out  1  result_lo == 0
- overflow  out  1  signed overflow on ADD/SUB; 0 otherwise
- div_by_zero  out  1  DIVU issued with dataB == 0

Behaviour:
- Reset: one clock, `clk`; `rst` is asynchronous and active-high.
  - State goes to IDLE.
  - in_ready = 1; out_valid = 0.
  - result_lo, result_hi = 0; all flags = 0.
  - Reset during BUSY or DONE aborts the operation with no output.
- FSM states: IDLE, BUSY, DONE.
- Handshake:
  - in_ready = (state == IDLE).
  - An operation is accepted on a rising edge where in_valid && in_ready; operands and op are latched at that edge.
  - Inputs are ignored outside IDLE.
- Single-cycle ops and undefined opcodes:
  - IDLE goes to DONE on the accept edge, so out_valid is visible 1 cycle after acceptance.
  - Undefined opcodes give result_lo = 0, result_hi = 0, overflow = 0.
- MULTU and DIVU:
  - IDLE goes to BUSY on the accept edge and loads the iteration counter with 0.
  - One iteration per edge in BUSY; the counter increments each edge.
  - The edge that completes iteration WIDTH-1 moves to DONE, so out_valid is visible WIDTH cycles after acceptance (32 at default).
- DONE:
  - out_valid = 1; result and flag outputs are held stable.
  - On an edge with out_ready = 1, go to IDLE and drop out_valid.
  - A new operation cannot be accepted on that same edge (in_ready is 0 in DONE), giving a minimum 1 idle cycle between results.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = (sign A == sign B') && (sign result != sign A), where B' = ~B for SUB.
  - SLT is a signed compare: result_lo = {0…0, A<B}.
  - SLL/SRL are logical, with zero fill.
  - MULTU gives the full 2·WIDTH product on {result_hi, result_lo}.
  - DIVU: result_lo = A / B, result_hi = A % B (unsigned).
- Boundaries:
  - DIVU with dataB == 0: completes via DONE after 1 cycle (no BUSY). Outputs are result_lo = all ones, result_hi = dataA, div_by_zero = 1.
  - Shift amount 0 passes dataA unchanged.
  - zero is computed from result_lo only, for every op.
  - out_valid held high indefinitely while out_ready = 0; no result is lost or overwritten.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: DIVU is implemented as described.
- Undefined:
  - Divider logic is removed and opcode 1101 behaves as an undefined op: 1-cycle latency, results 0, div_by_zero tied 0.
  - MULTU and all other ops are unchanged.

Test Plan:
- ADD 20,15 → result_lo=35, overflow=0, out_valid 1 cycle after accept. Then SUB 15,20 → 0xFFFFFFFB, zero=0.
- SLT 20,15 → result_lo=0. SLT 0xFFFFFFFF,1 → 1. ADD 0x7FFFFFFF,1 → 0x80000000, overflow=1.
- MULTU 5,10 → lo=50, hi=0, out_valid exactly 32 cycles after accept, in_ready=0 throughout. MULTU 0xFFFFFFFF,0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100,7 → lo=14, hi=2 after 32 cycles. DIVU 9,0 → lo=0xFFFFFFFF, hi=9, div_by_zero=1 after 1 cycle. With ALU_SEQ_DIV_EN undefined: DIVU 100,7 → lo=0, hi=0 after 1 cycle.
- Backpressure: AND 0xF0F0F0F0,0xFF00FF00 with out_ready=0 for 10 cycles → out_valid and result 0xF000F000 held stable, in_valid pulses ignored. out_ready=1 → IDLE next edge.
- Assert rst during cycle 12 of MULTU → out_valid=0, in_ready=1 immediately. After release, SLL 1,31 → 0x80000000.
